// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers, MTHI/MTLO writes and flush abort
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn_a, sgn_b, ge, div_zero;
  logic [WIDTH-1:0] a_abs, b_abs, diff, quo, rem, res_hi, res_lo;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] prod, step;
  // operand magnitudes, one shift-add / restoring-subtract step, and sign-corrected results
  always_comb begin
    sgn_a = !op[0] && srca[WIDTH-1];
    sgn_b = !op[0] && srcb[WIDTH-1];
    a_abs = sgn_a ? -srca : srca;
    b_abs = sgn_b ? -srcb : srcb;
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    t = acc_q[2*WIDTH-1:WIDTH-1];
    ge = t >= {1'b0, b_q};
    diff = t[WIDTH-1:0] - b_q;
    step = op_q[1] ? {ge ? diff : t[WIDTH-1:0], acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    div_zero = op_q[1] && b_q == '0;
    res_hi = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : div_zero ? a_q : rem;
    res_lo = !op_q[1] ? prod[WIDTH-1:0] : div_zero ? '1 : quo;
  end
  // control FSM: launch, iterate, correct and commit, with MTHI/MTLO writes only while idle
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    dbz_d = dbz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = CALC;
          op_d = op;
          sa_d = sgn_a;
          sb_d = sgn_b;
          a_d = srca;
          b_d = b_abs;
          acc_d = {{WIDTH{1'b0}}, a_abs};
          cnt_d = CW'(WIDTH - 1);
        end else if (!start) begin
          hi_d = hi_we ? wdata : hi_q;
          lo_d = lo_we ? wdata : lo_q;
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        state_d = flush ? IDLE : cnt_q == '0 ? FIX : CALC;
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d = res_hi;
          lo_d = res_lo;
          dbz_d = div_zero;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // architectural state and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  // operation datapath registers, only meaningful while an operation is in flight
  always_ff @(posedge clk) begin
    op_q <= op_d;
    sa_q <= sa_d;
    sb_q <= sb_d;
    a_q <= a_d;
    b_q <= b_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
  end
  assign busy = busy_q;
  assign done = done_q;
  assign dbz = dbz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic model
module tb_muldiv_unit;
  logic clk, reset, start, start8, flush, hi_we, lo_we;
  logic [1:0] op;
  logic [31:0] srca, srcb, wdata;
  logic busy, done, dbz, busy8, done8, dbz8;
  logic [31:0] hi, lo;
  logic [7:0] hi8, lo8;
  int checks = 0, failures = 0;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );
  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .srca(srca[7:0]), .srcb(srcb[7:0]),
    .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // MIPS mult/div semantics computed with plain 64-bit arithmetic at operand width w
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint m, ua, ub, sa, sb, p, q, r;
    m = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = ua >= (longint'(1) << (w - 1)) ? ua - (m + 1) : ua;
    sb = ub >= (longint'(1) << (w - 1)) ? ub - (m + 1) : ub;
    z = 1'b0;
    if (!o[1]) begin
      p = o[0] ? ua * ub : sa * sb;
      l = 32'(p & m);
      h = 32'((p >> w) & m);
    end else if (ub == 0) begin
      z = 1'b1;
      l = 32'(m);
      h = 32'(ua);
    end else begin
      q = o[0] ? ua / ub : sa / sb;
      r = o[0] ? ua % ub : sa % sb;
      l = 32'(q & m);
      h = 32'(r & m);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one operation from issue (cycle 0) to done, checking latency, busy window and results
  task automatic run_op(input int w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit we_at_start, input bit poke);
    logic [31:0] eh, el, lo0, ghi, glo;
    logic ez, gd, gb, gz;
    int cyc, nb, nd;
    model(w, o, a, b, eh, el, ez);
    lo0 = lo;
    op = o; srca = a; srcb = b;
    start = (w == 32); start8 = (w == 8);
    if (we_at_start) begin lo_we = 1'b1; wdata = 32'h5555_5555; end
    tick();
    start = 0; start8 = 0; lo_we = 0;
    if (we_at_start) chk("mtlo_with_start_dropped", lo, lo0);
    cyc = 1; nb = 0;
    gd = (w == 8) ? done8 : done;
    while (!gd && cyc < w + 20) begin
      nb += int'((w == 8) ? busy8 : busy);
      if (poke && cyc == 5) begin
        start = 1'b1; op = ~o; srca = $urandom; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      tick();
      start = 0; lo_we = 0;
      if (poke && cyc == 5) chk("mtlo_while_busy", lo, lo0);
      cyc++;
      gd = (w == 8) ? done8 : done;
    end
    gb = (w == 8) ? busy8 : busy;
    ghi = (w == 8) ? {24'h0, hi8} : hi;
    glo = (w == 8) ? {24'h0, lo8} : lo;
    gz = (w == 8) ? dbz8 : dbz;
    chk($sformatf("done_cycle w%0d op%0d", w, o), 64'(cyc), 64'(w + 2));
    chk("busy_cycles", 64'(nb), 64'(w + 1));
    chk("busy_at_done", gb, 1'b0);
    chk($sformatf("hi w%0d op%0d a=%0h b=%0h", w, o, a, b), ghi, eh);
    chk($sformatf("lo w%0d op%0d a=%0h b=%0h", w, o, a, b), glo, el);
    chk("dbz", gz, ez);
    if (poke) begin
      nd = 0;
      for (int i = 0; i < w + 4; i++) begin
        tick();
        nd += int'(done) + int'(busy);
      end
      chk("ignored_start_no_extra_activity", 64'(nd), 64'(0));
    end
  endtask

  // preload HI/LO, start a DIVU, abort it in cycle 10 with flush or reset
  task automatic abort_test(input bit use_reset);
    logic z0;
    int nd;
    z0 = dbz;
    hi_we = 1; wdata = 32'h11; tick();
    hi_we = 0; lo_we = 1; wdata = 32'h22; tick();
    lo_we = 0;
    start = 1; op = 2'b11; srca = 32'd1000; srcb = 32'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 0;
    end
    if (use_reset) reset = 1; else flush = 1;
    tick();
    reset = 0; flush = 0;
    chk(use_reset ? "reset_busy" : "flush_busy", busy, 1'b0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      nd += int'(done);
    end
    chk(use_reset ? "reset_no_done" : "flush_no_done", 64'(nd), 64'(0));
    chk(use_reset ? "reset_hi" : "flush_hi", hi, use_reset ? 32'h0 : 32'h11);
    chk(use_reset ? "reset_lo" : "flush_lo", lo, use_reset ? 32'h0 : 32'h22);
    chk(use_reset ? "reset_dbz" : "flush_dbz", dbz, use_reset ? 1'b0 : z0);
  endtask

  initial begin
    logic [31:0] pick [6];
    reset = 1; start = 0; start8 = 0; flush = 0; hi_we = 0; lo_we = 0;
    op = 0; srca = 0; srcb = 0; wdata = 0;
    repeat (3) tick();
    reset = 0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", dbz, 1'b0);
    hi_we = 1; wdata = 32'hABCD; tick();
    hi_we = 0;
    chk("mthi", hi, 32'hABCD);
    lo_we = 1; wdata = 32'h1234; tick();
    lo_we = 0;
    chk("mtlo", lo, 32'h1234);
    chk("mtlo_hi_kept", hi, 32'hABCD);
    run_op(32, 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    chk("mult_neg3x7_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg3x7_lo", lo, 32'hFFFF_FFEB);
    run_op(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(32, 2'b11, 32'd100, 32'd7, 0, 0);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(32, 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32, 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0);
    chk("div_7_m2", {hi, lo}, {32'h1, 32'hFFFF_FFFD});
    run_op(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
    run_op(32, 2'b10, 32'd5, 32'd0, 0, 0);
    chk("dbz_flag", dbz, 1'b1);
    chk("dbz_res", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    abort_test(0);
    run_op(32, 2'b00, 32'd2, 32'd3, 0, 0);
    chk("mult_after_dbz", {31'h0, dbz, lo}, {32'h0, 32'd6});
    run_op(32, 2'b01, 32'd12345, 32'd678, 1, 0);
    run_op(32, 2'b11, 32'd99999, 32'd13, 0, 1);
    abort_test(1);
    run_op(8, 2'b00, 32'h80, 32'h80, 0, 0);
    chk("w8_mult_m128sq", {hi8, lo8}, 16'h4000);
    pick = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      run_op(32, 2'($urandom_range(0, 3)), a, b, 0, 0);
    end
    for (int i = 0; i < 30; i++)
      run_op(8, 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
